// File: rtl/aes_inv_mixcol_unit_pkg.sv
// Shared constants, FSM encoding and index helpers for the
// iterative AES InvMixColumns unit.
package aes_inv_mixcol_unit_pkg;

   localparam int NUM_COLS = 4;
   localparam int COL_W    = 32;
   localparam int STATE_W  = COL_W * NUM_COLS;
   localparam int CNT_W    = $clog2(NUM_COLS);

   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } fsm_t;

   // Column 0 is the most significant word (FIPS-197 order).
   function automatic int col_lsb(input int c);
      return STATE_W - COL_W * (c + 1);
   endfunction

   function automatic int byte_lsb(input int b);
      return COL_W - 8 * (b + 1);
   endfunction

endpackage

// File: rtl/aes_inv_mixcol_unit_if.sv
// Input and output valid/ready channels of the
// InvMixColumns unit.
interface aes_inv_mixcol_unit_if;
   import aes_inv_mixcol_unit_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_state;
   logic               in_bypass;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] out_state;

   modport master (
      output in_valid,
      output in_state,
      output in_bypass,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_state
   );

   modport slave (
      input  in_valid,
      input  in_state,
      input  in_bypass,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_state
   );

endinterface

// File: rtl/aes_inv_mixcol_unit_gf256.sv
// GF(2^8) xtime and one row of the inverse MixColumns
// matrix, built only from XOR and xtime.
module gf256_xtime
   import aes_inv_mixcol_unit_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);

   assign y = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);

endmodule

module gf256_inv_mixcol_byte #(
   parameter int ROW_IDX = 0
) (
   input  logic [7:0] s0,
   input  logic [7:0] s1,
   input  logic [7:0] s2,
   input  logic [7:0] s3,
   output logic [7:0] byte_out
);

   logic [7:0] s    [4];
   logic [7:0] x2   [4];
   logic [7:0] x4   [4];
   logic [7:0] x8   [4];
   logic [7:0] term [4];

   assign s[0] = s0;
   assign s[1] = s1;
   assign s[2] = s2;
   assign s[3] = s3;

   for (genvar j = 0; j < 4; j++) begin : g_in
      // Row r is the base row {0e,0b,0d,09} rotated right by r.
      localparam int K = (j - ROW_IDX + 4) % 4;

      gf256_xtime u_x2 (.x(s[j]),  .y(x2[j]));
      gf256_xtime u_x4 (.x(x2[j]), .y(x4[j]));
      gf256_xtime u_x8 (.x(x4[j]), .y(x8[j]));

      if (K == 0) begin : g_e
         assign term[j] = x8[j] ^ x4[j] ^ x2[j];
      end else if (K == 1) begin : g_b
         assign term[j] = x8[j] ^ x2[j] ^ s[j];
      end else if (K == 2) begin : g_d
         assign term[j] = x8[j] ^ x4[j] ^ s[j];
      end else begin : g_9
         assign term[j] = x8[j] ^ s[j];
      end
   end

   assign byte_out = term[0] ^ term[1] ^ term[2] ^ term[3];

endmodule

// File: rtl/aes_inv_mixcol_unit.sv
// Iterative AES InvMixColumns: one column per cycle,
// valid/ready on both sides, per-block bypass.
module aes_inv_mixcol_unit
   import aes_inv_mixcol_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   aes_inv_mixcol_unit_if.slave bus
);

   fsm_t               fsm;
   logic [CNT_W-1:0]   col_cnt;
   logic [STATE_W-1:0] state_q;
   logic               bypass_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic [COL_W-1:0]   col_in;
   logic [COL_W-1:0]   col_out;
   logic [COL_W-1:0]   col_new;

   always_comb begin
      col_in = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col_cnt == CNT_W'(c)) begin
            col_in = state_q[col_lsb(c) +: COL_W];
         end
      end
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      gf256_inv_mixcol_byte #(
         .ROW_IDX (r)
      ) u_byte (
         .s0       (col_in[byte_lsb(0) +: 8]),
         .s1       (col_in[byte_lsb(1) +: 8]),
         .s2       (col_in[byte_lsb(2) +: 8]),
         .s3       (col_in[byte_lsb(3) +: 8]),
         .byte_out (col_out[byte_lsb(r) +: 8])
      );
   end

   // Bypass still walks all columns so round timing is uniform.
   assign col_new = bypass_q ? col_in : col_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= IDLE;
         col_cnt     <= '0;
         state_q     <= '0;
         bypass_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  state_q    <= bus.in_state;
                  bypass_q   <= bus.in_bypass;
                  col_cnt    <= '0;
                  in_ready_q <= 1'b0;
                  fsm        <= BUSY;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            BUSY: begin
               for (int c = 0; c < NUM_COLS; c++) begin
                  if (col_cnt == CNT_W'(c)) begin
                     state_q[col_lsb(c) +: COL_W] <= col_new;
                  end
               end
               col_cnt <= col_cnt + 1'b1;
               if (col_cnt == CNT_W'(NUM_COLS - 1)) begin
                  out_valid_q <= 1'b1;
                  fsm         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  fsm         <= IDLE;
               end
            end
            default: begin
               fsm <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = state_q;

endmodule

// File: tb/tb_aes_inv_mixcol_unit.sv
// Directed and round-trip bench for aes_inv_mixcol_unit.
// Expected values come from FIPS-197 vectors and a forward MixColumns model.
module tb_aes_inv_mixcol_unit;
   import aes_inv_mixcol_unit_pkg::*;

   logic clk;
   logic rst_n;

   aes_inv_mixcol_unit_if bus ();

   aes_inv_mixcol_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
   localparam logic [127:0] FP     = 128'h01010101_c6c6c6c6_01010101_c6c6c6c6;
   localparam logic [127:0] BYP    = 128'h00112233_44556677_8899aabb_ccddeeff;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int b = 0; b < 4; b++) a[b] = s[127-32*c-8*b -: 8];
         r[127-32*c -: 8]    = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
         r[127-32*c-8 -: 8]  = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
         r[127-32*c-16 -: 8] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
         r[127-32*c-24 -: 8] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
      end
      return r;
   endfunction

   task automatic send(input logic [127:0] s, input logic byp);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_ready", 128'(bus.in_ready), 128'(1));
      bus.in_valid  = 1'b1;
      bus.in_state  = s;
      bus.in_bypass = byp;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_state  = ~s;
      bus.in_bypass = ~byp;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [127:0] s,
                      input logic byp, input logic [127:0] exp);
      int lat;
      bus.out_ready = 1'b1;
      send(s, byp);
      wait_out(lat);
      chk({tag, "_lat"}, 128'(lat), 128'(4));
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
      chk({tag, "_state"}, bus.out_state, exp);
      @(posedge clk);
      #1;
      chk({tag, "_drain"}, 128'(bus.out_valid), 128'(0));
   endtask

   initial begin
      int           lat;
      int           n;
      logic         got;
      logic         rdy;
      logic [127:0] orig;
      logic [127:0] snap;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_state  = '0;
      bus.in_bypass = 1'b0;
      bus.out_ready = 1'b1;

      // Reset and first idle cycle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_out_state", bus.out_state, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("post_rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("post_rst_out_state", bus.out_state, 128'(0));

      // Known vectors, fixed points, bypass
      run("kv", KV_IN, 1'b0, KV_OUT);
      run("fixed", FP, 1'b0, FP);
      run("bypass", BYP, 1'b1, BYP);
      run("kv_after_byp", KV_IN, 1'b0, KV_OUT);

      // Backpressure in DONE with a competing input
      bus.out_ready = 1'b0;
      send(KV_IN, 1'b0);
      wait_out(lat);
      chk("bp_lat", 128'(lat), 128'(4));
      snap = bus.out_state;
      chk("bp_state", snap, KV_OUT);
      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            bus.in_valid  = 1'b1;
            bus.in_state  = FP;
            bus.in_bypass = 1'b0;
         end
         chk("bp_hold_valid", 128'(bus.out_valid), 128'(1));
         chk("bp_hold_state", bus.out_state, snap);
         chk("bp_hold_in_ready", 128'(bus.in_ready), 128'(0));
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_xfer_valid", 128'(bus.out_valid), 128'(0));
      chk("bp_idle_ready", 128'(bus.in_ready), 128'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp_accepted", 128'(bus.in_ready), 128'(0));
      wait_out(lat);
      chk("bp_next_lat", 128'(lat), 128'(4));
      chk("bp_next_state", bus.out_state, FP);
      @(posedge clk);
      #1;

      // Reset during the second BUSY cycle
      send(KV_IN, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
      chk("abort_in_ready", 128'(bus.in_ready), 128'(0));
      chk("abort_out_state", bus.out_state, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_idle_ready", 128'(bus.in_ready), 128'(1));
      chk("abort_idle_valid", 128'(bus.out_valid), 128'(0));
      run("kv_after_abort", KV_IN, 1'b0, KV_OUT);

      // Round trip through forward MixColumns with throttled output
      for (int i = 0; i < 200; i++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         send(fwd_mix(orig), 1'b0);
         n = 0;
         got = 1'b0;
         while (!got && n < 100) begin
            rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
               chk("rt_state", bus.out_state, orig);
               got = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
         end
         chk("rt_delivered", 128'(got), 128'(1));
      end
      bus.out_ready = 1'b1;
      chk("rt_end_idle", 128'(bus.out_valid), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_inv_mixcol_unit.md
Name: aes_inv_mixcol_unit

Overview:
Iterative AES InvMixColumns engine for the decrypt datapath. It accepts a full 128-bit state over a valid/ready handshake and processes one 32-bit column per cycle through four parallel inverse-matrix byte slices. It presents the result on a second valid/ready handshake with backpressure. It sits between InvSubBytes/InvShiftRows and AddRoundKey in the decrypt round. A per-block bypass input skips the transform for the final round.

Parameters:
NUM_COLS, 4, number of state columns; fixed at 4 and used to size the column counter.
STATE_W, 128, state width in bits; fixed at 32*NUM_COLS.

Ports:
clk  input  1  single clock; all state is updated on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input state valid
in_ready  output  1  unit can accept a state
in_state  input  128  input state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3 (FIPS-197 order)
in_bypass  input  1  when 1, the state is passed through unchanged (final decrypt round)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_state  output  128  result state, same byte order as in_state

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE and col_cnt=0.
  - State register and bypass flag clear.
  - in_ready=0 while in reset; it becomes 1 on the first cycle after deassertion.
  - out_valid=0 and out_state=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, register in_state and in_bypass, set col_cnt=0, and go to BUSY.
- BUSY:
  - in_ready=0 and out_valid=0.
  - Each cycle, column col_cnt of the state register is replaced by its transform, then col_cnt increments.
  - Transform: r0=0e*s0^0b*s1^0d*s2^09*s3, r1=09*s0^0e*s1^0b*s2^0d*s3, r2=0d*s0^09*s1^0e*s2^0b*s3, r3=0b*s0^0d*s1^09*s2^0e*s3. Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1.
  - If the bypass flag is set, the column is rewritten unchanged.
  - After col_cnt=3 is processed, go to DONE; col_cnt wraps to 0.
- DONE:
  - out_valid=1 and out_state equals the state register.
  - out_state is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0 in DONE.
- Timing: with the accept edge at cycle 0, out_valid rises after edge 4. Minimum initiation interval is 6 cycles.
- in_state and in_bypass are ignored outside the accept cycle. Changing them while BUSY has no effect.
- out_ready is ignored unless in DONE.
- Reset asserted in BUSY or DONE aborts the block. The result is discarded, with no partial output, and the unit comes back in IDLE.
- All products are computed with XOR/xtime only: 09=x8^x; 0b=x8^x2^x; 0d=x8^x4^x; 0e=x8^x4^x2, where x2=xtime(x), x4=xtime(x2), x8=xtime(x4). No lookup tables.
- Bypass latency equals normal latency, so the decrypt controller sees a uniform round timing.

Decomposition:
- Shared AES package holds:
  - STATE_W and NUM_COLS constants.
  - FSM state enum (IDLE/BUSY/DONE).
  - GF reduction constant 8'h1B.
  - Byte/column index helper functions.
- Sub-module gf256_inv_mixcol_byte, parameter ROW_IDX 0..3, inputs s0..s3 and output byte_out.
  - Built from gf256_xtime instances.
  - Four instances, one per row, form the column datapath.
- The top level holds the FSM, col_cnt, state register and column mux/demux.

Test Plan:
1. Reset/idle: hold rst_n=0, then release -> in_ready=1, out_valid=0 and out_state=0 on the first post-reset cycle.
2. Known vectors: column 8e4da1bc -> db135345; 9fdc589d -> f20a225c; d5d5d7d6 -> d4d4d4d5; 4d7ebdf8 -> 2d26314c. Place these in columns 0..3 of one state -> out_state=db135345_f20a225c_d4d4d4d5_2d26314c. out_valid rises exactly 4 cycles after the accept edge.
3. Fixed points and bypass: columns 01010101 and c6c6c6c6 map to themselves. State 00112233..eeff with in_bypass=1 -> output identical to input after the same 4-cycle latency.
4. Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_valid stays 1, out_state is stable, in_ready=0. Raise out_ready -> one transfer, then IDLE. A new in_valid asserted in DONE is not accepted until IDLE.
5. Reset mid-operation: pulse rst_n low during the 2nd BUSY cycle -> asynchronous clear, with out_valid=0 immediately. A following block (vector 2) completes correctly.
6. Round trip: 200 random states through a reference forward MixColumns, then this unit, with random out_ready throttling -> every output equals the original state, with no drops or duplicates.
